// File: rtl/press_debouncer_pkg.sv
// press_debounce_pkg: shared FSM state type and counter-width helper for press_debouncer.
package press_debounce_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction
endpackage

// File: rtl/press_debouncer_tick_gen.sv
// debounce_tick_gen: free-running prescaler, tick high for one clock every TICK_DIV clocks.
module debounce_tick_gen
  import press_debounce_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = cnt_w(TICK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/press_debouncer.sv
// press_debouncer: synchronises and debounces a push-button into press/release/held/long-press outputs.
// PRESS_AUTOREPEAT_EN: after long_press, repeat press every REPEAT_TICKS ticks while held.
module press_debouncer
  import press_debounce_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press,
  output logic release_p,
  output logic held,
  output logic long_press
);
  localparam int SW = cnt_w(STABLE_TICKS - 1);
  localparam int HW = cnt_w(LONG_TICKS);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_TICKS);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);
  if (TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS <= STABLE_TICKS || REPEAT_TICKS < 1) begin : g_bad_params
    $error("press_debouncer: illegal parameter combination");
  end
  state_t state;
  logic s1, s2, act, tick, stable_done, long_hit, hold_sat;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign act = s2 ^ ACTIVE_LOW;
  assign stable_done = tick && stable_cnt == S_LAST;
  assign long_hit = hold_cnt == H_LAST;
  assign hold_sat = hold_cnt == H_MAX;
`ifdef PRESS_AUTOREPEAT_EN
  localparam int RW = cnt_w(REPEAT_TICKS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt;
  logic rep_done;
  assign rep_done = hold_sat && rep_cnt == R_LAST;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
      state <= IDLE;
      stable_cnt <= '0;
      hold_cnt <= '0;
      press <= 1'b0;
      release_p <= 1'b0;
      held <= 1'b0;
      long_press <= 1'b0;
`ifdef PRESS_AUTOREPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      press <= 1'b0;
      release_p <= 1'b0;
      long_press <= 1'b0;
      case (state)
        IDLE:
          if (act) begin
            state <= PRESS_CHK;
            stable_cnt <= '0;
          end
        PRESS_CHK:
          if (!act) begin
            state <= IDLE;
            stable_cnt <= '0;
          end else if (stable_done) begin
            state <= HELD;
            stable_cnt <= '0;
            hold_cnt <= '0;
            press <= 1'b1;
            held <= 1'b1;
`ifdef PRESS_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (tick) stable_cnt <= stable_cnt + SW'(1);
        HELD:
          if (!act) begin
            state <= REL_CHK;
            stable_cnt <= '0;
          end else if (tick) begin
            hold_cnt <= hold_sat ? hold_cnt : hold_cnt + HW'(1);
            long_press <= long_hit;
`ifdef PRESS_AUTOREPEAT_EN
            // repeat counting only runs once the hold has saturated, i.e. after long_press
            rep_cnt <= (hold_sat && !rep_done) ? rep_cnt + RW'(1) : '0;
            press <= rep_done;
`endif
          end
        REL_CHK:
          if (act) begin
            state <= HELD;
            stable_cnt <= '0;
`ifdef PRESS_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (stable_done) begin
            state <= IDLE;
            stable_cnt <= '0;
            release_p <= 1'b1;
            held <= 1'b0;
          end else if (tick) stable_cnt <= stable_cnt + SW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_press_debouncer.sv
// tb_press_debouncer: directed checks of press_debouncer with TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2.
module tb_press_debouncer;
  logic clk = 1'b0, rst_n, btn_raw;
  logic press, release_p, held, long_press;
  int errors = 0, checks = 0;
  int np = 0, nr = 0, nl = 0, excl = 0;
  int lat, ll, base, base_r;
  press_debouncer #(
    .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(8), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .press(press), .release_p(release_p), .held(held), .long_press(long_press)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    np += int'(press);
    nr += int'(release_p);
    nl += int'(long_press);
    if ((press & release_p) | (press & long_press) | (release_p & long_press)) excl++;
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // lat = clocks from the edge that first samples the new btn_raw level to the pulse
  task automatic wait_pulse(input bit rel, input int max, output int l);
    l = -1;
    @(posedge clk);
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (rel ? release_p : press) begin
        l = k - 1;
        break;
      end
    end
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_press", press, 0);
    check("rst_release", release_p, 0);
    check("rst_long", long_press, 0);
    check("rst_held", held, 0);
    repeat (5) @(negedge clk);
    check("rst_held_late", held, 0);
    btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("idle_press_cnt", np, 0);
    check("idle_held", held, 0);
    btn_raw = 1'b0;
    wait_pulse(1'b0, 30, lat);
    check("press_lat_11_14", int'(lat >= 11 && lat <= 14), 1);
    check("press_held", held, 1);
    repeat (5) @(negedge clk);
    btn_raw = 1'b1;
    repeat (5) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("glitch_press_cnt", np, 1);
    check("glitch_release_cnt", nr, 0);
    check("glitch_held", held, 1);
    btn_raw = 1'b1;
    wait_pulse(1'b1, 30, lat);
    check("release_lat_11_14", int'(lat >= 11 && lat <= 14), 1);
    check("release_held", held, 0);
    repeat (10) @(negedge clk);
    #1;
    check("release_cnt", nr, 1);
    check("release_press_cnt", np, 1);
    for (int i = 0; i < 14; i++) begin
      btn_raw = i[0];
      repeat (3) @(negedge clk);
    end
    btn_raw = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("bounce_press_cnt", np, 1);
    check("bounce_held", held, 0);
    btn_raw = 1'b0;
    wait_pulse(1'b0, 30, lat);
    check("long_press_lat_11_14", int'(lat >= 11 && lat <= 14), 1);
    ll = -1;
    for (int m = 1; m <= 40; m++) begin
      @(negedge clk);
      if (long_press) begin
        ll = m;
        break;
      end
    end
    check("long_delay_clocks", ll, 32);
    #1;
    base = np;
    repeat (20) @(negedge clk);
    #1;
`ifdef PRESS_AUTOREPEAT_EN
    check("repeat_press_cnt", np - base, 2);
`else
    check("repeat_press_cnt", np - base, 0);
`endif
    check("long_cnt", nl, 1);
    check("long_still_held", held, 1);
    btn_raw = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    check("long_release_cnt", nr, 2);
    check("long_release_held", held, 0);
    btn_raw = 1'b0;
    wait_pulse(1'b0, 30, lat);
    check("pre_reset_held", held, 1);
    base_r = nr;
    rst_n = 1'b0;
    #1;
    check("mid_reset_held", held, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(1'b0, 30, lat);
    check("rearm_press_lat", lat, 11);
    check("rearm_held", held, 1);
    check("reset_no_release", nr - base_r, 0);
    check("pulse_exclusive", excl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
